// File: rtl/write_back_unit_pkg.sv
// Shared decode/write-back definitions: widths, opcode encodings, opcode groups,
// write-back classes and the write-back FSM state encoding.
package write_back_unit_pkg;

    localparam int unsigned D_BITS   = 32;
    localparam int unsigned CNT_BITS = 16;
    localparam int unsigned REG_BITS = 3;
    localparam int unsigned OP_BITS  = 7;

    localparam logic [OP_BITS-1:0] OP_ADD      = 7'h00;
    localparam logic [OP_BITS-1:0] OP_ADDF     = 7'h01;
    localparam logic [OP_BITS-1:0] OP_SUB      = 7'h02;
    localparam logic [OP_BITS-1:0] OP_SUBF     = 7'h03;
    localparam logic [OP_BITS-1:0] OP_AND      = 7'h04;
    localparam logic [OP_BITS-1:0] OP_OR       = 7'h05;
    localparam logic [OP_BITS-1:0] OP_XOR      = 7'h06;
    localparam logic [OP_BITS-1:0] OP_NAND     = 7'h07;
    localparam logic [OP_BITS-1:0] OP_NOR      = 7'h08;
    localparam logic [OP_BITS-1:0] OP_NXOR     = 7'h09;
    localparam logic [OP_BITS-1:0] OP_SHIFTR   = 7'h0A;
    localparam logic [OP_BITS-1:0] OP_SHIFTRA  = 7'h0B;
    localparam logic [OP_BITS-1:0] OP_SHIFTL   = 7'h0C;
    localparam logic [OP_BITS-1:0] OP_LOAD     = 7'h10;
    localparam logic [OP_BITS-1:0] OP_LOADC    = 7'h11;
    localparam logic [OP_BITS-1:0] OP_STORE    = 7'h12;
    localparam logic [OP_BITS-1:0] OP_JMP      = 7'h20;
    localparam logic [OP_BITS-1:0] OP_JMPR     = 7'h21;
    localparam logic [OP_BITS-1:0] OP_JMPCOND  = 7'h22;
    localparam logic [OP_BITS-1:0] OP_JMPRCOND = 7'h23;

    typedef enum logic [2:0] {
        GRP_ARITH = 3'd0,
        GRP_SHIFT = 3'd1,
        GRP_LDST  = 3'd2,
        GRP_JUMP  = 3'd3,
        GRP_UNDEF = 3'd4
    } op_group_e;

    typedef enum logic [1:0] {
        WB_NONE  = 2'd0,
        WB_ALU   = 2'd1,
        WB_MEM   = 2'd2
    } wb_class_e;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WB       = 2'd1,
        ST_WAIT_MEM = 2'd2
    } wb_state_e;

    // Coarse opcode grouping shared with the decode stage.
    function automatic op_group_e op_group(input logic [OP_BITS-1:0] op);
        op_group_e grp;
        grp = GRP_UNDEF;
        case (op)
            OP_ADD, OP_ADDF, OP_SUB, OP_SUBF, OP_AND, OP_OR, OP_XOR,
            OP_NAND, OP_NOR, OP_NXOR:                 grp = GRP_ARITH;
            OP_SHIFTR, OP_SHIFTRA, OP_SHIFTL:         grp = GRP_SHIFT;
            OP_LOAD, OP_LOADC, OP_STORE:              grp = GRP_LDST;
            OP_JMP, OP_JMPR, OP_JMPCOND, OP_JMPRCOND: grp = GRP_JUMP;
            default:                                  grp = GRP_UNDEF;
        endcase
        return grp;
    endfunction

endpackage

// File: rtl/write_back_unit_if.sv
// Execute/memory/read-stage facing bus of the write-back unit.
interface write_back_unit_if;
    import write_back_unit_pkg::*;

    logic                in_valid;
    logic                in_ready;
    logic [OP_BITS-1:0]  opcode;
    logic [REG_BITS-1:0] dest;
    logic [D_BITS-1:0]   alu_result;
    logic [D_BITS-1:0]   mem_rdata;
    logic                mem_rvalid;
    logic [REG_BITS-1:0] src0;
    logic [REG_BITS-1:0] src1;
    logic                fwd0_hit;
    logic                fwd1_hit;
    logic [D_BITS-1:0]   fwd_data;
    logic                stall;
    logic                rf_we;
    logic [REG_BITS-1:0] rf_waddr;
    logic [D_BITS-1:0]   rf_wdata;
    logic [CNT_BITS-1:0] wb_count;

    modport master (
        output in_valid, opcode, dest, alu_result, mem_rdata, mem_rvalid, src0, src1,
        input  in_ready, fwd0_hit, fwd1_hit, fwd_data, stall, rf_we, rf_waddr,
               rf_wdata, wb_count
    );

    modport slave (
        input  in_valid, opcode, dest, alu_result, mem_rdata, mem_rvalid, src0, src1,
        output in_ready, fwd0_hit, fwd1_hit, fwd_data, stall, rf_we, rf_waddr,
               rf_wdata, wb_count
    );

endinterface

// File: rtl/write_back_unit_wb_classify.sv
// Combinational opcode -> write-back class decode (also used by the hazard unit).
module wb_classify
    import write_back_unit_pkg::*;
(
    input  logic [OP_BITS-1:0] opcode,
    output wb_class_e          wb_class_c
);

    always_comb begin
        wb_class_c = WB_NONE;
        case (op_group(opcode))
            GRP_ARITH, GRP_SHIFT: wb_class_c = WB_ALU;
            // LOADC carries its merged constant in alu_result; only LOAD waits on memory.
            GRP_LDST: begin
                if (opcode == OP_LOAD) begin
                    wb_class_c = WB_MEM;
                end else if (opcode == OP_LOADC) begin
                    wb_class_c = WB_ALU;
                end
            end
            default: wb_class_c = WB_NONE;
        endcase
    end

endmodule

// File: rtl/write_back_unit.sv
// Final pipeline stage: retires results through the single register-file write
// port, holds upstream while a load is outstanding and forwards the in-flight write.
module write_back_unit
    import write_back_unit_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    write_back_unit_if.slave bus
);

    wb_state_e           state;
    wb_state_e           state_next;
    wb_class_e           wb_class_c;
    logic                ld_dest_c;
    logic                ld_alu_c;
    logic                ld_mem_c;
    logic [REG_BITS-1:0] lat_dest;
    logic [D_BITS-1:0]   lat_data;
    logic [CNT_BITS-1:0] cnt;

    wb_classify u_classify (
        .opcode     (bus.opcode),
        .wb_class_c (wb_class_c)
    );

    // Next-state and latch-enable decode.
    always_comb begin
        state_next = state;
        ld_dest_c  = 1'b0;
        ld_alu_c   = 1'b0;
        ld_mem_c   = 1'b0;
        case (state)
            ST_IDLE, ST_WB: begin
                state_next = ST_IDLE;
                if (bus.in_valid) begin
                    case (wb_class_c)
                        WB_ALU: begin
                            ld_dest_c  = 1'b1;
                            ld_alu_c   = 1'b1;
                            state_next = ST_WB;
                        end
                        WB_MEM: begin
                            ld_dest_c  = 1'b1;
                            state_next = ST_WAIT_MEM;
                        end
                        default: state_next = ST_IDLE;
                    endcase
                end
            end
            ST_WAIT_MEM: begin
                if (bus.mem_rvalid) begin
                    ld_mem_c   = 1'b1;
                    state_next = ST_WB;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Counter bumps on entry to WB so it already includes the write being shown.
    always_ff @(posedge clk) begin
        if (rst) begin
            lat_dest <= '0;
            lat_data <= '0;
            cnt      <= '0;
        end else begin
            if (ld_dest_c) begin
                lat_dest <= bus.dest;
            end
            if (ld_alu_c) begin
                lat_data <= bus.alu_result;
            end
            if (ld_mem_c) begin
                lat_data <= bus.mem_rdata;
            end
            if (state_next == ST_WB) begin
                cnt <= cnt + CNT_BITS'(1);
            end
        end
    end

    assign bus.in_ready = (state != ST_WAIT_MEM);
    assign bus.stall    = (state == ST_WAIT_MEM);
    assign bus.rf_we    = (state == ST_WB);
    assign bus.rf_waddr = lat_dest;
    assign bus.rf_wdata = lat_data;
    assign bus.wb_count = cnt;
    assign bus.fwd_data = lat_data;
    assign bus.fwd0_hit = (state == ST_WB) && (bus.src0 == lat_dest);
    assign bus.fwd1_hit = (state == ST_WB) && (bus.src1 == lat_dest);

endmodule

// File: tb/tb_write_back_unit.sv
// Directed and randomized bench for write_back_unit against a per-cycle
// behavioural model of retirement, load waiting and forwarding.
module tb_write_back_unit;
    import write_back_unit_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    write_back_unit_if bus();

    write_back_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    // Model state: pending write, outstanding load, last destination/value, count.
    logic                m_wr    = 1'b0;
    logic                m_load  = 1'b0;
    logic [REG_BITS-1:0] m_dest  = '0;
    logic [D_BITS-1:0]   m_data  = '0;
    logic [CNT_BITS-1:0] m_count = '0;

    localparam logic [OP_BITS-1:0] WRITING_OPS [14] = '{
        OP_ADD, OP_ADDF, OP_SUB, OP_SUBF, OP_AND, OP_OR, OP_XOR, OP_NAND,
        OP_NOR, OP_NXOR, OP_SHIFTR, OP_SHIFTRA, OP_SHIFTL, OP_LOADC
    };
    localparam logic [OP_BITS-1:0] ALL_OPS [20] = '{
        OP_ADD, OP_ADDF, OP_SUB, OP_SUBF, OP_AND, OP_OR, OP_XOR, OP_NAND,
        OP_NOR, OP_NXOR, OP_SHIFTR, OP_SHIFTRA, OP_SHIFTL, OP_LOADC,
        OP_LOAD, OP_STORE, OP_JMP, OP_JMPR, OP_JMPCOND, OP_JMPRCOND
    };

    // 1 = writes alu_result, 2 = load, 0 = no write.
    function automatic int ref_kind(input logic [OP_BITS-1:0] op);
        if (op == OP_LOAD) return 2;
        foreach (WRITING_OPS[i]) begin
            if (WRITING_OPS[i] == op) return 1;
        end
        return 0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [OP_BITS-1:0] op, input logic [REG_BITS-1:0] d,
                         input logic [D_BITS-1:0] alu, input logic mrv, input logic [D_BITS-1:0] mrd,
                         input logic [REG_BITS-1:0] s0, input logic [REG_BITS-1:0] s1);
        bus.in_valid   = v;
        bus.opcode     = op;
        bus.dest       = d;
        bus.alu_result = alu;
        bus.mem_rvalid = mrv;
        bus.mem_rdata  = mrd;
        bus.src0       = s0;
        bus.src1       = s1;
    endtask

    // Advance one clock, update the model from the inputs seen at the edge, check outputs.
    task automatic cyc();
        @(posedge clk);
        if (rst) begin
            m_wr = 1'b0; m_load = 1'b0; m_dest = '0; m_data = '0; m_count = '0;
        end else if (m_load) begin
            m_wr = bus.mem_rvalid;
            if (bus.mem_rvalid) begin
                m_data = bus.mem_rdata;
                m_load = 1'b0;
            end
        end else begin
            m_wr = 1'b0;
            if (bus.in_valid) begin
                case (ref_kind(bus.opcode))
                    1: begin m_wr = 1'b1; m_dest = bus.dest; m_data = bus.alu_result; end
                    2: begin m_load = 1'b1; m_dest = bus.dest; end
                    default: ;
                endcase
            end
        end
        if (m_wr) m_count = m_count + 16'd1;
        #1;
        chk("in_ready", 32'(bus.in_ready), 32'(!m_load));
        chk("stall",    32'(bus.stall),    32'(m_load));
        chk("rf_we",    32'(bus.rf_we),    32'(m_wr));
        chk("wb_count", 32'(bus.wb_count), 32'(m_count));
        chk("fwd0_hit", 32'(bus.fwd0_hit), 32'(m_wr && (bus.src0 == m_dest)));
        chk("fwd1_hit", 32'(bus.fwd1_hit), 32'(m_wr && (bus.src1 == m_dest)));
        if (m_wr) begin
            chk("rf_waddr", 32'(bus.rf_waddr), 32'(m_dest));
            chk("rf_wdata", bus.rf_wdata, m_data);
            chk("fwd_data", bus.fwd_data, m_data);
        end
    endtask

    initial begin
        logic [OP_BITS-1:0] op;
        drive(1'b0, OP_ADD, 3'd0, '0, 1'b0, '0, 3'd0, 3'd0);
        rst = 1'b1;
        cyc(); cyc();
        rst = 1'b0;
        chk("reset_waddr", 32'(bus.rf_waddr), 32'd0);
        chk("reset_wdata", bus.rf_wdata, 32'd0);

        // ADD r3 <- 0xA5, written the cycle after acceptance.
        drive(1'b1, OP_ADD, 3'd3, 32'h0000_00A5, 1'b0, '0, 3'd3, 3'd0);
        cyc();
        chk("add_wdata", bus.rf_wdata, 32'h0000_00A5);
        chk("add_count", 32'(bus.wb_count), 32'd1);

        // Back-to-back writes to r1, forward tracks the newest value.
        drive(1'b1, OP_SUB, 3'd1, 32'h10, 1'b0, '0, 3'd1, 3'd2);
        cyc();
        chk("b2b_first", bus.fwd_data, 32'h10);
        drive(1'b1, OP_SHIFTL, 3'd1, 32'h40, 1'b0, '0, 3'd1, 3'd2);
        cyc();
        chk("b2b_second", bus.rf_wdata, 32'h40);
        chk("b2b_fwd0", 32'(bus.fwd0_hit), 32'd1);
        drive(1'b0, OP_ADD, 3'd0, '0, 1'b0, '0, 3'd1, 3'd1);
        cyc();

        // LOAD r5, data returns after three stall cycles.
        drive(1'b1, OP_LOAD, 3'd5, 32'h1234_5678, 1'b0, '0, 3'd5, 3'd5);
        cyc();
        drive(1'b0, OP_ADD, 3'd0, '0, 1'b0, '0, 3'd5, 3'd5);
        cyc(); cyc();
        chk("load_stall", 32'(bus.stall), 32'd1);
        drive(1'b0, OP_ADD, 3'd0, '0, 1'b1, 32'hDEAD_BEEF, 3'd5, 3'd5);
        cyc();
        chk("load_wdata", bus.rf_wdata, 32'hDEAD_BEEF);
        chk("load_waddr", 32'(bus.rf_waddr), 32'd5);
        drive(1'b0, OP_ADD, 3'd0, '0, 1'b0, '0, 3'd0, 3'd0);
        cyc();

        // Non-writing ops and a stray memory return do nothing.
        drive(1'b1, OP_STORE, 3'd4, 32'hFFFF_FFFF, 1'b0, '0, 3'd4, 3'd4);
        cyc();
        drive(1'b1, OP_JMPR, 3'd6, 32'hFFFF_FFFF, 1'b0, '0, 3'd6, 3'd6);
        cyc();
        drive(1'b0, OP_ADD, 3'd0, '0, 1'b1, 32'hBAD0_BAD0, 3'd0, 3'd0);
        cyc();
        chk("none_count", 32'(bus.wb_count), 32'd4);

        // Reset while a load is outstanding drops it.
        drive(1'b1, OP_LOAD, 3'd2, '0, 1'b0, '0, 3'd2, 3'd2);
        cyc();
        drive(1'b0, OP_ADD, 3'd0, '0, 1'b1, 32'hCAFE_F00D, 3'd2, 3'd2);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        cyc();
        chk("rst_load_we", 32'(bus.rf_we), 32'd0);
        chk("rst_load_stall", 32'(bus.stall), 32'd0);

        // Randomized traffic with occasional resets.
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 1) == 0) op = ALL_OPS[$urandom_range(0, 19)];
            else op = OP_BITS'($urandom_range(0, 127));
            drive(1'($urandom_range(0, 3) != 0), op, 3'($urandom_range(0, 7)), $urandom,
                  1'($urandom_range(0, 2) == 0), $urandom,
                  3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
            rst = ($urandom_range(0, 79) == 0);
            cyc();
        end
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
